// File: rtl/fpu_cvt_to_float_seq.sv
// FCVT.S.W / FCVT.S.WU sequencer: 2-stage elastic int->float pipeline (S1 normalise, S2 round+pack).
// Optional FPU_CVT_FFLAGS_EN adds out_nx_o (inexact flag travelling with the result).
module fpu_cvt_to_float_seq #(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [2:0]       frm_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_is_unsigned_i,
    input  logic [2:0]       in_rm_i,
    input  logic [31:0]      in_data_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
`ifdef FPU_CVT_FFLAGS_EN
    output logic             out_nx_o,
`endif
    output logic             out_rm_err_o
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Returns 32 for an all-zero word; callers mask that case via the zero flag.
    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic l, input logic g, input logic s);
        logic up;
        case (rm)
            RM_RNE:  up = g & (l | s);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (g | s);
            RM_RUP:  up = !sign & (g | s);
            RM_RMM:  up = g;
            default: up = g & (l | s);
        endcase
        return up;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [30:0]      s1_norm_q,  s1_norm_d;
    logic [7:0]       s1_exp_q,   s1_exp_d;
    logic             s1_zero_q,  s1_zero_d;
    logic [2:0]       s1_rm_q,    s1_rm_d;
    logic             s1_err_q,   s1_err_d;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_err_q;

    logic        s1_adv, s2_adv, accept, s2_load;
    logic [2:0]  rm_raw;
    logic signed [31:0] operand_s;
    logic [31:0] mag;
    logic [5:0]  lz;
    logic        rnd_l, rnd_g, rnd_s, rnd_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_r;

    always_comb begin
        s2_adv     = !s2_valid_q | out_ready_i;
        s1_adv     = !s1_valid_q | s2_adv;
        in_ready_o = s1_adv & !flush_i;
        accept     = in_valid_i & in_ready_o;
        s2_load    = s2_adv & s1_valid_q & !flush_i;

        s1_valid_d = flush_i ? 1'b0 : (s1_adv ? accept : s1_valid_q);
        s2_valid_d = flush_i ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
    end

    // Stage S1 inputs: rm resolution, sign/magnitude, leading-zero normalise
    always_comb begin
        rm_raw    = (in_rm_i == 3'b111) ? frm_i : in_rm_i;
        s1_err_d  = (rm_raw == 3'b101) | (rm_raw == 3'b110) | (rm_raw == 3'b111);
        s1_rm_d   = s1_err_d ? RM_RNE : rm_raw;
        operand_s = signed'(in_data_i);
        s1_sign_d = !in_is_unsigned_i & in_data_i[31];
        mag       = s1_sign_d ? unsigned'(-operand_s) : in_data_i;
        lz        = lzc32(mag);
        // The leading one is implicit after normalisation, so only bits [30:0] are kept.
        s1_norm_d = 31'(mag << lz);
        s1_exp_d  = 8'd158 - {2'b00, lz};
        s1_zero_d = (mag == 32'd0);
    end

    // Stage S2 inputs: round and pack; a carry out of the fraction bumps the exponent
    always_comb begin
        rnd_l     = s1_norm_q[8];
        rnd_g     = s1_norm_q[7];
        rnd_s     = |s1_norm_q[6:0];
        rnd_up    = round_up(s1_rm_q, s1_sign_q, rnd_l, rnd_g, rnd_s);
        frac_sum  = {1'b0, s1_norm_q[30:8]} + 24'(rnd_up);
        exp_r     = s1_exp_q + {7'd0, frac_sum[23]};
        s2_data_d = s1_zero_q ? 32'h0000_0000 : {s1_sign_q, exp_r, frac_sum[22:0]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_sign_q <= s1_sign_d;
            s1_norm_q <= s1_norm_d;
            s1_exp_q  <= s1_exp_d;
            s1_zero_q <= s1_zero_d;
            s1_rm_q   <= s1_rm_d;
            s1_err_q  <= s1_err_d;
            s1_tag_q  <= in_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_data_q <= 32'd0;
            s2_tag_q  <= '0;
            s2_err_q  <= 1'b0;
        end else if (s2_load) begin
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s1_tag_q;
            s2_err_q  <= s1_err_q;
        end
    end

`ifdef FPU_CVT_FFLAGS_EN
    logic s2_nx_q, s2_nx_d;

    assign s2_nx_d = !s1_zero_q & (rnd_g | rnd_s);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_nx_q <= 1'b0;
        end else if (s2_load) begin
            s2_nx_q <= s2_nx_d;
        end
    end

    assign out_nx_o = s2_nx_q;
`endif

    assign out_valid_o  = s2_valid_q;
    assign out_data_o   = s2_data_q;
    assign out_tag_o    = s2_tag_q;
    assign out_rm_err_o = s2_err_q;

endmodule

// File: tb/tb_fpu_cvt_to_float_seq.sv
// Scoreboard bench for fpu_cvt_to_float_seq: directed vectors, expected results queued at accept.
module tb_fpu_cvt_to_float_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_uns, out_valid, out_ready, out_err, out_nx;
    logic [2:0]  frm, in_rm;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_tag, out_tag;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
        logic        nx;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_cvt_to_float_seq #(.TAG_W(5)) dut (
        .clk_i(clk), .reset_i(rst), .flush_i(flush), .frm_i(frm),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_is_unsigned_i(in_uns),
        .in_rm_i(in_rm), .in_data_i(in_data), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_tag_o(out_tag),
`ifdef FPU_CVT_FFLAGS_EN
        .out_nx_o(out_nx),
`endif
        .out_rm_err_o(out_err)
    );

`ifndef FPU_CVT_FFLAGS_EN
    assign out_nx = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops the next expected result whenever a result is consumed
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {27'd0, out_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
                    chk("out_rm_err", {31'd0, out_err}, {31'd0, e.err});
`ifdef FPU_CVT_FFLAGS_EN
                    chk("out_nx", {31'd0, out_nx}, {31'd0, e.nx});
`endif
                end
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic uns, input logic [2:0] rm,
                         input logic [2:0] f, input logic [4:0] tag);
        in_data = d; in_uns = uns; in_rm = rm; frm = f; in_tag = tag; in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic uns, input logic [2:0] rm,
                        input logic [2:0] f, input logic [4:0] tag,
                        input logic [31:0] ed, input logic eerr, input logic enx);
        int n;
        n = 0;
        drive(d, uns, rm, f, tag);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        else sb.push_back('{data: ed, tag: tag, err: eerr, nx: enx});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'd0, 1'b0, 3'b000, 3'b000, 5'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_nx", {31'd0, out_nx}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // 1: basic conversion and 2-cycle latency
        send(32'h0000_0001, 1'b0, 3'b000, 3'b000, 5'd1, 32'h3F80_0000, 1'b0, 1'b0);
        chk("lat_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_two_cycles", {31'd0, out_valid}, 32'd1);
        drain();

        // 2: dynamic rm, most negative, zero, plus a few sign/rounding mixes
        send(32'hFFFF_FFFF, 1'b0, 3'b111, 3'b001, 5'd2, 32'hBF80_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b0, 3'b000, 3'b000, 5'd3, 32'hCF00_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b0, 3'b011, 3'b000, 5'd4, 32'h0000_0000, 1'b0, 1'b0);
        send(32'hFFFF_FFFD, 1'b0, 3'b010, 3'b000, 5'd5, 32'hC040_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b1, 3'b000, 3'b000, 5'd6, 32'h4F00_0000, 1'b0, 1'b0);
        drain();

        // 3: unsigned all-ones, carry into exponent vs truncation
        send(32'hFFFF_FFFF, 1'b1, 3'b000, 3'b000, 5'd7, 32'h4F80_0000, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 3'b001, 3'b000, 5'd8, 32'h4F7F_FFFF, 1'b0, 1'b1);
        drain();

        // 4: exact tie on 0x01000001 under each mode, illegal rm fallback
        send(32'h0100_0001, 1'b0, 3'b000, 3'b000, 5'd9,  32'h4B80_0000, 1'b0, 1'b1);
        send(32'h0100_0001, 1'b0, 3'b011, 3'b000, 5'd10, 32'h4B80_0001, 1'b0, 1'b1);
        send(32'h0100_0001, 1'b0, 3'b100, 3'b000, 5'd11, 32'h4B80_0001, 1'b0, 1'b1);
        send(32'h0100_0001, 1'b0, 3'b101, 3'b000, 5'd12, 32'h4B80_0000, 1'b1, 1'b1);
        send(32'h0100_0001, 1'b0, 3'b111, 3'b111, 5'd13, 32'h4B80_0000, 1'b1, 1'b1);
        send(32'h0100_0001, 1'b1, 3'b010, 3'b000, 5'd14, 32'h4B80_0000, 1'b0, 1'b1);
        send(32'hFEFF_FFFF, 1'b0, 3'b010, 3'b000, 5'd15, 32'hCB80_0001, 1'b0, 1'b1);
        send(32'hFEFF_FFFF, 1'b0, 3'b011, 3'b000, 5'd16, 32'hCB80_0000, 1'b0, 1'b1);
        drain();

        // 5: backpressure fills both stages, then releases at full rate
        out_ready = 1'b0;
        send(32'h0000_0002, 1'b0, 3'b000, 3'b000, 5'd17, 32'h4000_0000, 1'b0, 1'b0);
        send(32'h0000_0003, 1'b0, 3'b000, 3'b000, 5'd18, 32'h4040_0000, 1'b0, 1'b0);
        drive(32'h0000_0004, 1'b0, 3'b000, 3'b000, 5'd19);
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        held = out_data;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold_data", out_data, held);
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{data: 32'h4080_0000, tag: 5'd19, err: 1'b0, nx: 1'b0});
        chk("burst0", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("burst1", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("burst2", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        drain();

        // 6: flush with two ops in flight
        out_ready = 1'b0;
        send(32'h0000_0005, 1'b0, 3'b000, 3'b000, 5'd20, 32'h40A0_0000, 1'b0, 1'b0);
        send(32'h0000_0006, 1'b0, 3'b000, 3'b000, 5'd21, 32'h40C0_0000, 1'b0, 1'b0);
        flush = 1'b1;
        drive(32'h0000_0007, 1'b0, 3'b000, 3'b000, 5'd22);
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("flush_stale_data", out_data, 32'h40A0_0000);
        @(posedge clk); #1;
        send(32'h0000_0008, 1'b0, 3'b000, 3'b000, 5'd23, 32'h4100_0000, 1'b0, 1'b0);
        chk("post_flush_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("post_flush_latency", {31'd0, out_valid}, 32'd1);
        drain();

        // Reset with an op in flight discards it
        send(32'h0000_0009, 1'b0, 3'b000, 3'b000, 5'd24, 32'h4110_0000, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midreset_no_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("midreset_data", out_data, 32'd0);
        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
